// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_ctrl_pkg
//  Control-word layout, nop constant and forwarding-select encoding.
//  Revision: 1.0
// ============================================================================
package cpu_ctrl_pkg;

    localparam int CTRL_W         = 10;
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_WBSEL_LSB = 4;
    localparam int CTRL_MEMWE_BIT = 6;
    localparam int CTRL_WRE_BIT   = 7;
    localparam int CTRL_LOAD_BIT  = 8;
    localparam int CTRL_VWRE_BIT  = 9;

    typedef struct packed {
        logic       vector_wre;
        logic       load;
        logic       wre;
        logic       mem_we;
        logic [1:0] wb_sel;
        logic [3:0] aluOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // Upper decoder bits are meaningless to the pipe and are discarded here.
    function automatic ctrl_t unpack_ctrl(input logic [15:0] word);
        return ctrl_t'(word[CTRL_W-1:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
//  ctrl_fwd_unit
//  Per-operand forwarding select: EX/MEM result first, then MEM/WB, else RF.
//  Revision: 1.0
// ============================================================================
module ctrl_fwd_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic             rs_used_i,
    input  logic             mem_wre_i,
    input  logic             mem_load_i,
    input  logic [REG_W-1:0] mem_rd_i,
    input  logic             wb_wre_i,
    input  logic [REG_W-1:0] wb_rd_i,
    output fwd_sel_e         fwd_o
);

    logic rs_ok;
    logic hit_mem;
    logic hit_wb;

    assign rs_ok   = rs_used_i && ((rs_i != '0) || !R0_ZERO);
    // A load still in MEM has no result yet; the load-use stall moves it to WB first.
    assign hit_mem = rs_ok && mem_wre_i && !mem_load_i && (mem_rd_i == rs_i);
    assign hit_wb  = rs_ok && wb_wre_i && (wb_rd_i == rs_i);

    always_comb begin
        fwd_o = FWD_RF;
        if (hit_mem) begin
            fwd_o = FWD_MEM;
        end else if (hit_wb) begin
            fwd_o = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  ctrl_pipe
//  ID/EX, EX/MEM, MEM/WB control registers with load-use stall, flush, forwarding.
//  Revision: 1.0
// ============================================================================
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id_control_signals,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [1:0]       id_rs_used,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic [3:0]       ex_aluOp,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_write_memory_enable,
    output logic             mem_load,
    output logic             wb_wre,
    output logic             wb_vector_wre,
    output logic [1:0]       wb_select_writeback_data_mux,
    output logic [REG_W-1:0] wb_rd
);

    ctrl_t            idex_ctrl_q,  idex_ctrl_d;
    logic [REG_W-1:0] idex_rd_q,    idex_rd_d;
    logic [REG_W-1:0] idex_rs1_q,   idex_rs1_d;
    logic [REG_W-1:0] idex_rs2_q,   idex_rs2_d;
    logic [1:0]       idex_used_q,  idex_used_d;
    ctrl_t            exmem_ctrl_q;
    logic [REG_W-1:0] exmem_rd_q;
    ctrl_t            memwb_ctrl_q;
    logic [REG_W-1:0] memwb_rd_q;

    logic     hazard;
    logic     bubble;
    logic     ex_rd_ok;
    logic     unused_hi;
    fwd_sel_e fwd_a_sel;
    fwd_sel_e fwd_b_sel;

    assign unused_hi = ^id_control_signals[15:CTRL_W];

    assign ex_rd_ok = (idex_rd_q != '0) || !R0_ZERO;
    assign hazard   = idex_ctrl_q.load && idex_ctrl_q.wre && ex_rd_ok &&
                      ((id_rs_used[0] && (id_rs1 == idex_rd_q)) ||
                       (id_rs_used[1] && (id_rs2 == idex_rd_q)));
    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign stall    = hazard && !ex_branch_taken;
    assign bubble   = stall || ex_branch_taken;

    always_comb begin
        idex_ctrl_d = unpack_ctrl(id_control_signals);
        idex_rd_d   = id_rd;
        idex_rs1_d  = id_rs1;
        idex_rs2_d  = id_rs2;
        idex_used_d = id_rs_used;
        if (bubble) begin
            idex_ctrl_d = CTRL_NOP;
            idex_rd_d   = '0;
            idex_rs1_d  = '0;
            idex_rs2_d  = '0;
            idex_used_d = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_ctrl_q  <= CTRL_NOP;
            idex_rd_q    <= '0;
            idex_rs1_q   <= '0;
            idex_rs2_q   <= '0;
            idex_used_q  <= 2'b00;
            exmem_ctrl_q <= CTRL_NOP;
            exmem_rd_q   <= '0;
            memwb_ctrl_q <= CTRL_NOP;
            memwb_rd_q   <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rd_q    <= idex_rd_d;
            idex_rs1_q   <= idex_rs1_d;
            idex_rs2_q   <= idex_rs2_d;
            idex_used_q  <= idex_used_d;
            exmem_ctrl_q <= idex_ctrl_q;
            exmem_rd_q   <= idex_rd_q;
            memwb_ctrl_q <= exmem_ctrl_q;
            memwb_rd_q   <= exmem_rd_q;
        end
    end

    ctrl_fwd_unit #(.REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_fwd_a (
        .rs_i       (idex_rs1_q),
        .rs_used_i  (idex_used_q[0]),
        .mem_wre_i  (exmem_ctrl_q.wre),
        .mem_load_i (exmem_ctrl_q.load),
        .mem_rd_i   (exmem_rd_q),
        .wb_wre_i   (memwb_ctrl_q.wre),
        .wb_rd_i    (memwb_rd_q),
        .fwd_o      (fwd_a_sel)
    );

    ctrl_fwd_unit #(.REG_W(REG_W), .R0_ZERO(R0_ZERO)) u_fwd_b (
        .rs_i       (idex_rs2_q),
        .rs_used_i  (idex_used_q[1]),
        .mem_wre_i  (exmem_ctrl_q.wre),
        .mem_load_i (exmem_ctrl_q.load),
        .mem_rd_i   (exmem_rd_q),
        .wb_wre_i   (memwb_ctrl_q.wre),
        .wb_rd_i    (memwb_rd_q),
        .fwd_o      (fwd_b_sel)
    );

    assign fwd_a                        = fwd_a_sel;
    assign fwd_b                        = fwd_b_sel;
    assign ex_aluOp                     = idex_ctrl_q.aluOp;
    assign mem_write_memory_enable      = exmem_ctrl_q.mem_we;
    assign mem_load                     = exmem_ctrl_q.load;
    assign wb_wre                       = memwb_ctrl_q.wre;
    assign wb_vector_wre                = memwb_ctrl_q.vector_wre;
    assign wb_select_writeback_data_mux = memwb_ctrl_q.wb_sel;
    assign wb_rd                        = memwb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  tb_ctrl_pipe
//  Directed bench: both R0_ZERO settings checked every cycle against a word-level model.
//  Revision: 1.0
// ============================================================================
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] id_w;
    logic [3:0]  id_rd, id_rs1, id_rs2;
    logic [1:0]  id_used;
    logic        br;

    logic       st  [2];
    logic [3:0] alu [2];
    logic [1:0] fa  [2];
    logic [1:0] fb  [2];
    logic       mwe [2];
    logic       mld [2];
    logic       wwe [2];
    logic       wvw [2];
    logic [1:0] wsl [2];
    logic [3:0] wrd [2];

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_W(4), .R0_ZERO(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .id_control_signals(id_w), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_used), .ex_branch_taken(br),
        .stall(st[0]), .ex_aluOp(alu[0]), .fwd_a(fa[0]), .fwd_b(fb[0]),
        .mem_write_memory_enable(mwe[0]), .mem_load(mld[0]), .wb_wre(wwe[0]),
        .wb_vector_wre(wvw[0]), .wb_select_writeback_data_mux(wsl[0]), .wb_rd(wrd[0])
    );

    ctrl_pipe #(.REG_W(4), .R0_ZERO(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .id_control_signals(id_w), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_used), .ex_branch_taken(br),
        .stall(st[1]), .ex_aluOp(alu[1]), .fwd_a(fa[1]), .fwd_b(fb[1]),
        .mem_write_memory_enable(mwe[1]), .mem_load(mld[1]), .wb_wre(wwe[1]),
        .wb_vector_wre(wvw[1]), .wb_select_writeback_data_mux(wsl[1]), .wb_rd(wrd[1])
    );

    // Model: each stage holds the raw instruction it carries; fields are read from
    // the word bit positions only when an output is needed.
    typedef struct {
        logic [15:0] w;
        logic [3:0]  rd, rs1, rs2;
        logic [1:0]  used;
    } ins_t;

    localparam ins_t NOP_I = '{w: 16'h0, rd: 4'h0, rs1: 4'h0, rs2: 4'h0, used: 2'b00};

    ins_t ex_m  [2] = '{NOP_I, NOP_I};
    ins_t mem_m [2] = '{NOP_I, NOP_I};
    ins_t wb_m  [2] = '{NOP_I, NOP_I};

    // k==0 hardwires r0, k==1 treats r0 as an ordinary register
    function automatic logic m_stall(int k);
        ins_t e   = ex_m[k];
        logic rok = (e.rd != 4'h0) || (k == 1);
        logic dep = (id_used[0] && id_rs1 == e.rd) || (id_used[1] && id_rs2 == e.rd);
        return !br && e.w[8] && e.w[7] && rok && dep;
    endfunction

    function automatic logic [1:0] m_fwd(int k, logic [3:0] rs, logic used);
        logic rok = (rs != 4'h0) || (k == 1);
        if (!used || !rok)                                           return 2'b00;
        if (mem_m[k].w[7] && !mem_m[k].w[8] && mem_m[k].rd == rs)    return 2'b01;
        if (wb_m[k].w[7] && wb_m[k].rd == rs)                        return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ins_t nx;
            nx = '{w: id_w, rd: id_rd, rs1: id_rs1, rs2: id_rs2, used: id_used};
            if (br || m_stall(k)) nx = NOP_I;
            if (rst) begin
                ex_m[k]  <= NOP_I;
                mem_m[k] <= NOP_I;
                wb_m[k]  <= NOP_I;
            end else begin
                ex_m[k]  <= nx;
                mem_m[k] <= ex_m[k];
                wb_m[k]  <= mem_m[k];
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("stall[%0d]", k), 8'(st[k]),  8'(m_stall(k)));
                chk($sformatf("ex_aluOp[%0d]", k), 8'(alu[k]), 8'(ex_m[k].w[3:0]));
                chk($sformatf("fwd_a[%0d]", k), 8'(fa[k]), 8'(m_fwd(k, ex_m[k].rs1, ex_m[k].used[0])));
                chk($sformatf("fwd_b[%0d]", k), 8'(fb[k]), 8'(m_fwd(k, ex_m[k].rs2, ex_m[k].used[1])));
                chk($sformatf("mem_we[%0d]", k), 8'(mwe[k]), 8'(mem_m[k].w[6]));
                chk($sformatf("mem_load[%0d]", k), 8'(mld[k]), 8'(mem_m[k].w[8]));
                chk($sformatf("wb_wre[%0d]", k), 8'(wwe[k]), 8'(wb_m[k].w[7]));
                chk($sformatf("wb_vwre[%0d]", k), 8'(wvw[k]), 8'(wb_m[k].w[9]));
                chk($sformatf("wb_sel[%0d]", k), 8'(wsl[k]), 8'(wb_m[k].w[5:4]));
                chk($sformatf("wb_rd[%0d]", k), 8'(wrd[k]), 8'(wb_m[k].rd));
            end
        end
    end

    task automatic put(input logic [15:0] w, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [1:0] used, input logic b);
        id_w = w; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_used = used; br = b;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
            nxt();
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_zero"}, {st[k], alu[k], fa[k], mwe[k]}, 8'h00);
            chk({tag, "_zero2"}, {fb[k], mld[k], wwe[k], wvw[k], wsl[k], 1'b0}, 8'h00);
            chk({tag, "_wbrd"}, 8'(wrd[k]), 8'h00);
        end
    endtask

    task automatic t_basic(input logic [15:0] w, input string tag);
        put(w, 4'h3, 4'h0, 4'h0, 2'b00, 1'b0);
        nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk({tag, "_ex_aluOp"}, 8'(alu[0]), 8'h01);
        nxt(); nxt();
        mid();
        chk({tag, "_wb_wre"}, 8'(wwe[0]), 8'h01);
        chk({tag, "_wb_rd"},  8'(wrd[0]), 8'h03);
        chk({tag, "_wb_sel"}, 8'(wsl[0]), 8'h00);
        idle(3);
    endtask

    initial begin
        rst = 1'b1;
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        nxt(); nxt();
        rst = 1'b0;
        mid();
        all_zero("reset");
        chk_en = 1'b1;

        t_basic(16'h0081, "basic");

        // load-use: one stall cycle, bubble, then WB forwarding
        put(16'h0181, 4'h5, 4'h0, 4'h0, 2'b00, 1'b0);
        nxt();
        put(16'h0082, 4'h6, 4'h5, 4'h0, 2'b01, 1'b0);
        mid(); chk("lu_stall", 8'(st[0]), 8'h01);
        nxt();
        mid(); chk("lu_stall_end", 8'(st[0]), 8'h00);
        chk("lu_bubble", 8'(alu[0]), 8'h00);
        nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("lu_ex_aluOp", 8'(alu[0]), 8'h02);
        chk("lu_fwd_a", 8'(fa[0]), 8'h02);
        idle(3);

        // EX/MEM over MEM/WB priority
        put(16'h0081, 4'h2, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0082, 4'h2, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0083, 4'h7, 4'h0, 4'h2, 2'b10, 1'b0); nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("prio_fwd_b", 8'(fb[0]), 8'h01);
        idle(3);
        put(16'h0081, 4'h2, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);    nxt();
        put(16'h0083, 4'h7, 4'h0, 4'h2, 2'b10, 1'b0); nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("wb_fwd_b", 8'(fb[0]), 8'h02);
        idle(3);

        // flush squashes a store in ID
        put(16'h0005, 4'h0, 4'h1, 4'h2, 2'b11, 1'b0); nxt();
        put(16'h0040, 4'h0, 4'h3, 4'h4, 2'b11, 1'b1); nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("flush_bubble", 8'(alu[0]), 8'h00);
        nxt();
        mid(); chk("flush_mem_we", 8'(mwe[0]), 8'h00);
        idle(3);

        // r0 writer then r0 reader
        put(16'h0081, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0082, 4'h4, 4'h0, 4'h0, 2'b01, 1'b0);
        mid(); chk("r0_stall", 8'(st[0]), 8'h00);
        nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("r0_fwd_a", 8'(fa[0]), 8'h00);
        chk("r0_fwd_a_nozero", 8'(fa[1]), 8'h01);
        idle(3);

        // r0 load-use only stalls when r0 is an ordinary register
        put(16'h0181, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0082, 4'h4, 4'h0, 4'h0, 2'b01, 1'b0);
        mid(); chk("r0_lu_stall", 8'(st[0]), 8'h00);
        chk("r0_lu_stall_nozero", 8'(st[1]), 8'h01);
        idle(4);

        // vector write: carried only, never forwarded
        put(16'h0200, 4'h6, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0082, 4'h1, 4'h6, 4'h6, 2'b11, 1'b0); nxt();
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid(); chk("vec_no_fwd", 8'({fa[0], fb[0]}), 8'h00);
        nxt();
        mid(); chk("vec_wb", 8'(wvw[0]), 8'h01);
        idle(3);

        // reset with loads and stores in flight
        put(16'h0181, 4'h1, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'h0040, 4'h0, 4'h1, 4'h2, 2'b00, 1'b0); nxt();
        put(16'h0081, 4'h4, 4'h0, 4'h0, 2'b00, 1'b0);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        put(16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
        mid();
        all_zero("midrst");
        idle(2);

        // ignored upper bits
        t_basic(16'hFC81, "hibits");
        put(16'hFDC1, 4'h9, 4'h0, 4'h0, 2'b00, 1'b0); nxt();
        put(16'hFC82, 4'h6, 4'h9, 4'h0, 2'b01, 1'b0);
        mid(); chk("hibits_stall", 8'(st[0]), 8'h01);
        nxt();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
